// File: rtl/fifo_defs.sv
// Shared definitions for the transmit-layer FIFO family.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fifo_defs;

  // Bit positions inside the sticky error vector
  localparam int ERR_OVF  = 0;
  localparam int ERR_UDF  = 1;
  localparam int ERR_BITS = 2;

  // Width pair used by the transmit-layer lane/class queues
  localparam int TX_DATA_WIDTH = 6;
  localparam int TX_ADDR_WIDTH = 2;

endpackage

// File: rtl/fifo_umbral_param_if.sv
// Push/pop, threshold and status bundle for fifo_umbral_param.
// Latency: n/a (wiring only).
// Backpressure: n/a; rejected pushes/pops are reported through the error flags.
interface fifo_umbral_param_if
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int ADDR_WIDTH = TX_ADDR_WIDTH
);
  logic                  init;
  logic                  wr_enable;
  logic                  rd_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH:0]   umbral_alto;
  logic [ADDR_WIDTH:0]   umbral_bajo;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow_error;
  logic                  underflow_error;

  // Producer/consumer side (drives requests, observes status)
  modport master (
    output init, wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo,
    input  data_out, data_valid, fifo_count, full, empty, almost_full,
           almost_empty, overflow_error, underflow_error
  );

  // FIFO side
  modport slave (
    input  init, wr_enable, rd_enable, data_in, umbral_alto, umbral_bajo,
    output data_out, data_valid, fifo_count, full, empty, almost_full,
           almost_empty, overflow_error, underflow_error
  );
endinterface

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH register array, one write port and one read port.
// Latency: write lands at the clock edge; read is combinational from raddr_i.
// Backpressure: none; the owner decides when a write is legal.
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; only the pointers define valid contents
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_umbral_param.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds and sticky errors.
// Latency: pop data appears registered one clock after an accepted rd_enable.
// Backpressure: push at full without a pop is dropped (overflow); pop at empty is dropped (underflow).
module fifo_umbral_param
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int ADDR_WIDTH = TX_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               reset_L,
  fifo_umbral_param_if.slave bus
);
  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [ERR_BITS-1:0]   err_q, err_d;

  logic                  full_w, empty_w;
  logic                  push_acc, pop_acc, mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it
  assign full_w   = (count_q == DEPTH_C);
  assign empty_w  = (count_q == '0);
  assign pop_acc  = bus.rd_enable && !empty_w;
  assign push_acc = bus.wr_enable && (!full_w || pop_acc);
  assign mem_we   = push_acc && bus.init;

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Next-state: pointers, occupancy, output register and sticky errors; init overrides all
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = '0;
    data_valid_d = 1'b0;
    err_d        = err_q;

    if (!bus.init) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        data_out_d   = rd_data;
        data_valid_d = 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.wr_enable && full_w && !pop_acc) err_d[ERR_OVF] = 1'b1;
      if (bus.rd_enable && empty_w)            err_d[ERR_UDF] = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.data_out        = data_out_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.fifo_count      = count_q;
  assign bus.full            = full_w;
  assign bus.empty           = empty_w;
  assign bus.almost_full     = (count_q >= bus.umbral_alto) && !full_w;
  assign bus.almost_empty    = (count_q <= bus.umbral_bajo) && !empty_w;
  assign bus.overflow_error  = err_q[ERR_OVF];
  assign bus.underflow_error = err_q[ERR_UDF];

  a_count_range: assert property (@(posedge clk) disable iff (!reset_L)
    count_q <= DEPTH_C);
  a_count_ptrs: assert property (@(posedge clk) disable iff (!reset_L)
    full_w || (count_q == {1'b0, wr_ptr_q - rd_ptr_q}));
endmodule
